interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 179 +++++++++++++++++
 tb/tb_interrupt_controller.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Latches interrupt flags from CHANNELS raw lines. Each line is edge- or
// level-triggered, selected per channel by EDGE_MASK. The lowest-indexed
// enabled flag is presented to the CPU as one request, and the CPU accepts it
// with ack. On ack the handler vector (VECTOR_BASE + channel + 1) is latched,
// and no further request is issued until service_done. Only software clears
// flags, by writing 1s to flag_clr.
//
// Ports
//   clk          : sole clock, rising edge
//   reset_n      : synchronous active-low reset
//   irq_in       : [CHANNELS] raw interrupt lines, synchronous to clk
//   mask_wr      : load mask register from mask_data
//   mask_data    : [CHANNELS] new enable mask (1 = enabled)
//   flag_clr     : [CHANNELS] write-1-to-clear strobe for flags
//   int_enable   : CPU global interrupt enable
//   ack          : CPU accepts the presented request
//   service_done : handler has returned
//   irq_request  : request presented to the CPU
//   vector       : [PC_WIDTH] vector of the granted channel
//   flags        : [CHANNELS] latched interrupt flags
//   wake         : some enabled flag is set (ignores int_enable)
//   state_dbg    : [2] current FSM state (0 idle, 1 pending, 2 service)
//
// Handshake: irq_request is a level that is high for the whole PENDING state.
// The CPU answers with a one-cycle ack pulse. An ack in the same cycle as
// irq_request transfers the grant. An ack seen while no request is up is
// dropped. service_done is a one-cycle pulse that ends SERVICE. Outside
// SERVICE it is dropped.
// -----------------------------------------------------------------------------
module interrupt_controller #(
    parameter int                   CHANNELS    = 15,
    parameter int                   PC_WIDTH    = 13,
    parameter logic [PC_WIDTH-1:0]  VECTOR_BASE = PC_WIDTH'('h1100),
    parameter logic [CHANNELS-1:0]  EDGE_MASK   = '1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] irq_in,
    input  logic                mask_wr,
    input  logic [CHANNELS-1:0] mask_data,
    input  logic [CHANNELS-1:0] flag_clr,
    input  logic                int_enable,
    input  logic                ack,
    input  logic                service_done,
    output logic                irq_request,
    output logic [PC_WIDTH-1:0] vector,
    output logic [CHANNELS-1:0] flags,
    output logic                wake,
    output logic [1:0]          state_dbg
);

    localparam int SEL_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CHANNELS-1:0] irq_prev_q, irq_prev_d;
    logic [CHANNELS-1:0] flags_q, flags_d;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic [PC_WIDTH-1:0] vector_q, vector_d;
    logic                wake_q, wake_d;

    logic [CHANNELS-1:0] set_vec;
    logic [CHANNELS-1:0] pending;
    logic                any_pending;
    logic [SEL_W-1:0]    sel;

    // ------------------------------------------------------------------
    // Flag capture. An edge channel sets on a 0->1 transition of irq_in
    // against the stored previous value. A level channel sets on every
    // cycle it is high. A set wins over a clear in the same cycle, so an
    // interrupt that arrives during a software clear is not lost.
    // ------------------------------------------------------------------
    always_comb begin
        set_vec    = (EDGE_MASK & irq_in & ~irq_prev_q) | (~EDGE_MASK & irq_in);
        flags_d    = (flags_q & ~flag_clr) | set_vec;
        irq_prev_d = irq_in;
        mask_d     = mask_wr ? mask_data : mask_q;
    end

    // These use the current mask register. A mask_wr in the ack cycle
    // therefore does not affect the grant.
    assign pending     = flags_q & mask_q;
    assign any_pending = |pending;
    assign wake_d      = any_pending;

    // Lowest set index wins. The loop scans downward, so the last match
    // is the lowest index.
    always_comb begin
        sel = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        vector_d = vector_q;
        if (state_q == PENDING && ack) begin
            vector_d = VECTOR_BASE + PC_WIDTH'(sel) + PC_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_pending && int_enable) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                // ack takes precedence over withdrawal in the same cycle
                if (ack) begin
                    state_d = SERVICE;
                end else if (!any_pending || !int_enable) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (service_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        irq_request = (state_q == PENDING);
        state_dbg   = state_q;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_prev_q <= '0;
            flags_q    <= '0;
            mask_q     <= '0;
            vector_q   <= VECTOR_BASE;
            wake_q     <= 1'b0;
        end else begin
            irq_prev_q <= irq_prev_d;
            flags_q    <= flags_d;
            mask_q     <= mask_d;
            vector_q   <= vector_d;
            wake_q     <= wake_d;
        end
    end

    assign flags  = flags_q;
    assign vector = vector_q;
    assign wake   = wake_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//
// Directed bench for interrupt_controller. u_dut uses the default parameters,
// so every channel is edge-triggered. u_lvl shares its inputs and makes
// channel 0 level-triggered. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

    localparam int CH = 15;
    localparam int PW = 13;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic          clk;
    logic          reset_n;
    logic [CH-1:0] irq_in;
    logic          mask_wr;
    logic [CH-1:0] mask_data;
    logic [CH-1:0] flag_clr;
    logic          int_enable;
    logic          ack;
    logic          service_done;

    logic          irq_request;
    logic [PW-1:0] vector;
    logic [CH-1:0] flags;
    logic          wake;
    logic [1:0]    state_dbg;

    logic          l_irq_request;
    logic [PW-1:0] l_vector;
    logic [CH-1:0] l_flags;
    logic          l_wake;
    logic [1:0]    l_state_dbg;

    int n_cmp;
    int n_fail;

    interrupt_controller u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .irq_in       (irq_in),
        .mask_wr      (mask_wr),
        .mask_data    (mask_data),
        .flag_clr     (flag_clr),
        .int_enable   (int_enable),
        .ack          (ack),
        .service_done (service_done),
        .irq_request  (irq_request),
        .vector       (vector),
        .flags        (flags),
        .wake         (wake),
        .state_dbg    (state_dbg)
    );

    interrupt_controller #(
        .EDGE_MASK (15'h7FFE)
    ) u_lvl (
        .clk          (clk),
        .reset_n      (reset_n),
        .irq_in       (irq_in),
        .mask_wr      (mask_wr),
        .mask_data    (mask_data),
        .flag_clr     (flag_clr),
        .int_enable   (int_enable),
        .ack          (ack),
        .service_done (service_done),
        .irq_request  (l_irq_request),
        .vector       (l_vector),
        .flags        (l_flags),
        .wake         (l_wake),
        .state_dbg    (l_state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        irq_in       = '0;
        mask_wr      = 1'b0;
        mask_data    = '0;
        flag_clr     = '0;
        int_enable   = 1'b0;
        ack          = 1'b0;
        service_done = 1'b0;

        // ---- reset state
        step();
        step();
        check("rst_irq_request", 32'(irq_request), 32'h0);
        check("rst_wake",        32'(wake),        32'h0);
        check("rst_flags",       32'(flags),       32'h0);
        check("rst_vector",      32'(vector),      32'h1100);
        check("rst_state",       32'(state_dbg),   32'(S_IDLE));

        // ---- release, enable all channels
        reset_n    = 1'b1;
        mask_wr    = 1'b1;
        mask_data  = 15'h7FFF;
        int_enable = 1'b1;
        step();
        mask_wr    = 1'b0;

        // ---- channel 0 rises: 2-cycle request latency, vector 1101
        irq_in = 15'h0001;
        step();
        check("ch0_flag_n1",    32'(flags),       32'h0001);
        check("ch0_req_n1",     32'(irq_request), 32'h0);
        step();
        check("ch0_req_n2",     32'(irq_request), 32'h1);
        check("ch0_wake",       32'(wake),        32'h1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("ch0_vector",     32'(vector),      32'h1101);
        check("ch0_state_srv",  32'(state_dbg),   32'(S_SERVICE));
        check("ch0_req_srv",    32'(irq_request), 32'h0);
        check("ch0_flag_kept",  32'(flags),       32'h0001);
        flag_clr     = 15'h0001;
        service_done = 1'b1;
        step();
        flag_clr     = '0;
        service_done = 1'b0;
        irq_in       = '0;
        step();
        check("ch0_state_idle", 32'(state_dbg),   32'(S_IDLE));
        check("ch0_flag_clr",   32'(flags),       32'h0);
        check("ch0_wake_off",   32'(wake),        32'h0);

        // ---- channels 14 and 11 together: 11 first, then 14
        irq_in = 15'h4800;
        step();
        check("dual_flags",     32'(flags),       32'h4800);
        step();
        check("dual_req",       32'(irq_request), 32'h1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("dual_vec11",     32'(vector),      32'h110C);
        flag_clr     = 15'h0800;
        service_done = 1'b1;
        step();
        flag_clr     = '0;
        service_done = 1'b0;
        check("dual_flags_left", 32'(flags),      32'h4000);
        step();
        check("dual_req2",      32'(irq_request), 32'h1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("dual_vec14",     32'(vector),      32'h110F);
        flag_clr     = 15'h4000;
        service_done = 1'b1;
        step();
        flag_clr     = '0;
        service_done = 1'b0;
        irq_in       = '0;
        step();

        // ---- channel 6 with int_enable low: wake only
        int_enable = 1'b0;
        irq_in     = 15'h0040;
        step();
        step();
        check("ch6_wake",       32'(wake),        32'h1);
        check("ch6_no_req",     32'(irq_request), 32'h0);
        step();
        check("ch6_no_req2",    32'(irq_request), 32'h0);
        int_enable = 1'b1;
        step();
        check("ch6_req",        32'(irq_request), 32'h1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("ch6_vector",     32'(vector),      32'h1107);
        flag_clr     = 15'h0040;
        service_done = 1'b1;
        step();
        flag_clr     = '0;
        service_done = 1'b0;
        irq_in       = '0;
        step();

        // ---- set and clear on the same channel in one cycle: set wins
        int_enable = 1'b0;
        irq_in     = 15'h0008;
        flag_clr   = 15'h0008;
        step();
        flag_clr   = '0;
        check("setclr_flag",    32'(flags),       32'h0008);
        flag_clr   = 15'h0008;
        step();
        flag_clr   = '0;
        irq_in     = '0;
        check("setclr_cleared", 32'(flags),       32'h0);

        // ---- masked channel 2 latches a flag but neither requests nor wakes
        mask_wr    = 1'b1;
        mask_data  = 15'h7FFB;
        step();
        mask_wr    = 1'b0;
        int_enable = 1'b1;
        irq_in     = 15'h0004;
        step();
        step();
        check("masked_flag",    32'(flags),       32'h0004);
        check("masked_req",     32'(irq_request), 32'h0);
        check("masked_wake",    32'(wake),        32'h0);
        flag_clr = 15'h0004;
        irq_in   = '0;
        step();
        flag_clr = '0;

        // ---- ack and mask write together: grant uses the old mask
        irq_in = 15'h0022;
        step();
        step();
        check("ackmask_req",    32'(irq_request), 32'h1);
        ack       = 1'b1;
        mask_wr   = 1'b1;
        mask_data = 15'h7FFD;
        step();
        ack       = 1'b0;
        mask_wr   = 1'b0;
        check("ackmask_vector", 32'(vector),      32'h1102);
        flag_clr     = 15'h0022;
        service_done = 1'b1;
        step();
        flag_clr     = '0;
        service_done = 1'b0;
        irq_in       = '0;
        step();

        // ---- level channel 0 on u_lvl. Line already high at reset release:
        // both instances flag it on the first active cycle.
        reset_n    = 1'b0;
        int_enable = 1'b0;
        irq_in     = 15'h0001;
        mask_wr    = 1'b1;
        mask_data  = 15'h7FFF;
        step();
        check("lvl_rst_flags",  32'(l_flags),     32'h0);
        reset_n = 1'b1;
        step();
        mask_wr = 1'b0;
        check("edge_at_release", 32'(flags),      32'h0001);
        check("lvl_flag_set",   32'(l_flags),     32'h0001);
        flag_clr = 15'h0001;
        step();
        flag_clr = '0;
        check("lvl_flag_resets", 32'(l_flags),    32'h0001);
        check("edge_flag_clr",  32'(flags),       32'h0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("lvl_ack_idle_st",  32'(l_state_dbg), 32'(S_IDLE));
        check("lvl_ack_idle_vec", 32'(l_vector),    32'h1100);
        check("lvl_ack_idle_req", 32'(l_irq_request), 32'h0);
        check("lvl_wake",         32'(l_wake),      32'h1);

        // ---- reset during SERVICE
        irq_in     = '0;
        int_enable = 1'b1;
        step();
        irq_in = 15'h0010;
        step();
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("rs_state_srv",   32'(state_dbg),   32'(S_SERVICE));
        check("rs_vector_pre",  32'(vector),      32'h1105);
        reset_n = 1'b0;
        step();
        check("rs_state",       32'(state_dbg),   32'(S_IDLE));
        check("rs_flags",       32'(flags),       32'h0);
        check("rs_req",         32'(irq_request), 32'h0);
        check("rs_wake",        32'(wake),        32'h0);
        check("rs_vector",      32'(vector),      32'h1100);
        reset_n = 1'b1;
        irq_in  = '0;
        step();
        check("rs_post_req",    32'(irq_request), 32'h0);
        check("rs_post_state",  32'(state_dbg),   32'(S_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
